// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - Write/read handshake and status bundle for sync_fifo (optional SYNC_FIFO_ERR_FLAGS_EN flags)
interface sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_wr_dv;
  logic [WIDTH-1:0] i_wr_data;
  logic             i_rd_en;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_rd_dv;
  logic             o_full;
  logic             o_empty;
  logic             o_af;
  logic             o_ae;
  logic [CW-1:0]    o_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_wr_dv, i_wr_data, i_rd_en,
    input  o_rd_data, o_rd_dv, o_full, o_empty, o_af, o_ae, o_count,
    input  o_overflow, o_underflow
  );

  modport slave (
    input  i_wr_dv, i_wr_data, i_rd_en,
    output o_rd_data, o_rd_dv, o_full, o_empty, o_af, o_ae, o_count,
    output o_overflow, o_underflow
  );
`else
  modport master (
    output i_wr_dv, i_wr_data, i_rd_en,
    input  o_rd_data, o_rd_dv, o_full, o_empty, o_af, o_ae, o_count
  );

  modport slave (
    input  i_wr_dv, i_wr_data, i_rd_en,
    output o_rd_data, o_rd_dv, o_full, o_empty, o_af, o_ae, o_count
  );
`endif
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - Single-clock FIFO with registered read data and status flags (optional SYNC_FIFO_ERR_FLAGS_EN sticky error flags)
module sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  sync_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] rd_data;
  logic             rd_dv;
  logic             full;
  logic             empty;
  logic             af;
  logic             ae;
  logic             wr_acc;
  logic             rd_acc;

  // Accept decisions use the registered flags, which always match count.
  assign wr_acc = bus.i_wr_dv && !full;
  assign rd_acc = bus.i_rd_en && !empty;

  // Occupancy after this edge; simultaneous accepted write and read cancel.
  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage array, no reset so it maps onto RAM.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.i_wr_data;
    end
  end

  // Pointers, read register and flags; flags come from next-state count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      rd_dv   <= 1'b0;
      full    <= 1'b0;
      empty   <= 1'b1;
      af      <= 1'b0;
      ae      <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_dv <= rd_acc;
      count <= count_nxt;
      full  <= (count_nxt == FULL_C);
      empty <= (count_nxt == '0);
      af    <= (count_nxt >= AF_C);
      ae    <= (count_nxt <= AE_C);
    end
  end

  assign bus.o_rd_data = rd_data;
  assign bus.o_rd_dv   = rd_dv;
  assign bus.o_count   = count;
  assign bus.o_full    = full;
  assign bus.o_empty   = empty;
  assign bus.o_af      = af;
  assign bus.o_ae      = ae;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow;
  logic underflow;

  // Sticky record of any request made against a full or empty FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.i_wr_dv && full) begin
        overflow <= 1'b1;
      end
      if (bus.i_rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  assign bus.o_overflow  = overflow;
  assign bus.o_underflow = underflow;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - Randomized queue-model bench for sync_fifo
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  sync_fifo_if #(.WIDTH(8), .DEPTH(8)) bus ();

  sync_fifo #(
    .WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a queue of stored words plus the expected registered outputs.
  logic [7:0] q[$];
  logic [7:0] m_rd_data = 8'h00;
  logic       m_rd_dv = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_rd_data = 8'h00;
        m_rd_dv   = 1'b0;
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
      end else begin
        automatic bit wr = (bus.i_wr_dv === 1'b1);
        automatic bit rd = (bus.i_rd_en === 1'b1);
        automatic int n  = q.size();
        if (wr && n == 8) m_ovf = 1'b1;
        if (rd && n == 0) m_udf = 1'b1;
        m_rd_dv = rd && (n > 0);
        if (rd && n > 0) m_rd_data = q.pop_front();
        if (wr && n < 8) q.push_back(bus.i_wr_data);
      end
    end
  end

  // Every falling edge: DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("count", 32'(bus.o_count), 32'(q.size()));
      chk("full",  32'(bus.o_full),  32'(q.size() == 8));
      chk("empty", 32'(bus.o_empty), 32'(q.size() == 0));
      chk("af",    32'(bus.o_af),    32'(q.size() >= 6));
      chk("ae",    32'(bus.o_ae),    32'(q.size() <= 2));
      chk("rd_dv", 32'(bus.o_rd_dv), 32'(m_rd_dv));
      chk("rd_data", 32'(bus.o_rd_data), 32'(m_rd_data));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("overflow",  32'(bus.o_overflow),  32'(m_ovf));
      chk("underflow", 32'(bus.o_underflow), 32'(m_udf));
`endif
    end
  end

  task automatic cyc(input logic wr, input logic [7:0] d, input logic rd);
    bus.i_wr_dv   = wr;
    bus.i_wr_data = d;
    bus.i_rd_en   = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"},   32'(bus.o_count),   32'd0);
    chk({tag, "_rd_data"}, 32'(bus.o_rd_data), 32'd0);
    chk({tag, "_rd_dv"},   32'(bus.o_rd_dv),   32'd0);
    chk({tag, "_full"},    32'(bus.o_full),    32'd0);
    chk({tag, "_af"},      32'(bus.o_af),      32'd0);
    chk({tag, "_empty"},   32'(bus.o_empty),   32'd1);
    chk({tag, "_ae"},      32'(bus.o_ae),      32'd1);
  endtask

  initial begin
    bus.i_wr_dv   = 1'b0;
    bus.i_wr_data = 8'h00;
    bus.i_rd_en   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Fill with 0x11..0x18, write accepted on the first edge after release.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0);
      chk("fill_count", 32'(bus.o_count), 32'(i));
      chk("fill_ae",    32'(bus.o_ae),    32'(i <= 2));
      chk("fill_af",    32'(bus.o_af),    32'(i >= 6));
      chk("fill_full",  32'(bus.o_full),  32'(i == 8));
    end

    // Drain in order.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_dv",   32'(bus.o_rd_dv),   32'd1);
      chk("drain_data", 32'(bus.o_rd_data), 32'(8'h10 + i));
    end
    chk("drain_empty", 32'(bus.o_empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("idle_dv",   32'(bus.o_rd_dv),   32'd0);
    chk("idle_hold", 32'(bus.o_rd_data), 32'h18);

    // Full with simultaneous write+read: write dropped, read taken.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    cyc(1'b1, 8'hAA, 1'b1);
    chk("fullwr_count", 32'(bus.o_count),   32'd7);
    chk("fullwr_data",  32'(bus.o_rd_data), 32'h11);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("fullwr_ovf", 32'(bus.o_overflow), 32'd1);
`endif
    for (int i = 2; i <= 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("post_full_data", 32'(bus.o_rd_data), 32'(8'h10 + i));
    end
    chk("post_full_empty", 32'(bus.o_empty), 32'd1);

    // Empty with simultaneous write+read: read dropped, write taken.
    cyc(1'b1, 8'h5C, 1'b1);
    chk("emptyrd_dv",    32'(bus.o_rd_dv), 32'd0);
    chk("emptyrd_count", 32'(bus.o_count), 32'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("emptyrd_udf", 32'(bus.o_underflow), 32'd1);
`endif
    cyc(1'b0, 8'h00, 1'b1);
    chk("emptyrd_next", 32'(bus.o_rd_data), 32'h5C);

    // Mid-cycle reset with 5 stored words.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
    chk("pre_rst_count", 32'(bus.o_count), 32'd5);
    bus.i_wr_dv = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_dv",   32'(bus.o_rd_dv),   32'd1);
    chk("post_rst_data", 32'(bus.o_rd_data), 32'h77);

    // Steady concurrent traffic at occupancy 4, wrapping the pointers.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(i + 4), 1'b1);
      chk("steady_count", 32'(bus.o_count),   32'd4);
      chk("steady_data",  32'(bus.o_rd_data), 32'(i));
    end

    // Randomized traffic with phases biased toward filling, draining, balance.
    for (int i = 0; i < 3000; i++) begin
      automatic int wp = (((i / 200) % 3) == 0) ? 80 : ((((i / 200) % 3) == 1) ? 20 : 50);
      automatic logic w = ($urandom_range(0, 99) < wp);
      automatic logic r = ($urandom_range(0, 99) < (100 - wp));
      cyc(w, 8'($urandom), r);
    end

    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 256, word capacity; power of two, >=4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4, almost-full threshold (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 4, almost-empty threshold (1..DEPTH-1).
REQ-005 SHALL have port: i_clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port: i_rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
REQ-007 SHALL have port: i_wr_dv  input  1  write request, data valid.
REQ-008 SHALL have port: i_wr_data  input  WIDTH  write data.
REQ-009 SHALL have port: i_rd_en  input  1  read request.
REQ-010 SHALL have port: o_rd_data  output  WIDTH  read data.
REQ-011 SHALL have port: o_rd_dv  output  1  read data valid.
REQ-012 SHALL have port: o_full / o_empty  output  1 each  occupancy == DEPTH / == 0.
REQ-013 SHALL have port: o_af / o_ae  output  1 each  occupancy >= AF_LEVEL / <= AE_LEVEL.
REQ-014 SHALL have port: o_count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL accept a write on a rising edge iff i_wr_dv=1 and o_full=0; the word is stored at the write pointer, which increments modulo DEPTH.
REQ-016 SHALL accept a read on a rising edge iff i_rd_en=1 and o_empty=0; the word at the read pointer is registered into o_rd_data and the read pointer increments modulo DEPTH.
REQ-017 SHALL assert o_rd_dv for exactly one cycle following each accepted read (1-cycle read latency); o_rd_dv=0 after a rejected or absent read.
REQ-018 SHALL hold o_rd_data unchanged when no read is accepted.
REQ-019 SHALL update o_count on the edge: +1 write only, -1 read only, unchanged for both or neither.
REQ-020 SHALL register o_full, o_empty, o_af, o_ae from the next-state count, so they are consistent with o_count every cycle.
REQ-021 Simultaneous write+read when full: SHALL reject the write, accept the read; o_count becomes DEPTH-1.
REQ-022 Simultaneous write+read when empty: SHALL reject the read (o_rd_dv=0 next cycle), accept the write; o_count becomes 1.
REQ-023 Simultaneous write+read otherwise: SHALL accept both; o_count unchanged; read returns the oldest word, never the one being written.
REQ-024 SHALL return words in write order (FIFO) across pointer wrap-around.
REQ-025 SHALL infer the storage as a RAM array without reset.

Reset
REQ-026 SHALL, while i_rst_n=0, force immediately (asynchronously) pointers=0, o_count=0, o_rd_data=0, o_rd_dv=0, o_full=0, o_af=0, o_empty=1, o_ae=1.
REQ-027 SHALL discard all stored words on reset asserted mid-operation; first read after release returns only post-reset data.
REQ-028 SHALL accept a write on the first rising edge after i_rst_n deasserts.

Configuration
REQ-029 Macro SYNC_FIFO_ERR_FLAGS_EN SHALL, when defined, add outputs o_overflow and o_underflow (1 bit each, reset 0).
REQ-030 With macro defined: o_overflow SHALL set sticky on any edge with i_wr_dv=1 and o_full=1; o_underflow SHALL set sticky on any edge with i_rd_en=1 and o_empty=1; both clear only by reset.
REQ-031 Without macro: the ports SHALL not exist and rejected requests SHALL be silently dropped.

Verification (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-032 Reset, then write 0x11..0x18 over 8 cycles -> o_count 1..8, o_ae clears at count 3, o_af sets at 6, o_full at 8.
REQ-033 From full, read 8 cycles -> o_rd_data 0x11..0x18 each one cycle after i_rd_en with o_rd_dv=1; o_empty=1 after the last.
REQ-034 Full, assert i_wr_dv=1 with 0xAA and i_rd_en=1 -> o_count=7, 0xAA not stored, o_overflow=1 if macro defined.
REQ-035 Empty, assert i_wr_dv=1 with 0x5C and i_rd_en=1 -> o_rd_dv=0 next cycle, o_count=1, next read returns 0x5C; o_underflow=1 if macro defined.
REQ-036 Fill to 5, drop i_rst_n mid-cycle -> outputs at reset values before next edge; after release write 0x77 and read -> 0x77.
REQ-037 Run 20 cycles of concurrent write/read at count=4 with incrementing data -> o_count stays 4, data in order across wrap.
